hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage CPU. It generates the enable and flush controls for the PC, the IF/ID register and the ID/EXE register, plus a freeze for the EXE/MEM/WB registers. It handles three cases: load-use bubbles, taken-branch flushes, and multi-cycle data-memory waits with a timeout. It sits beside the decode stage, watches decode and execute fields, and drives the pipeline registers' enable and flush inputs.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/hazard_ctrl_sat_counter.sv | 27 ++
 rtl/hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the five-stage pipeline control blocks.
//   hc_state_t : hazard controller FSM states
//   REG_W      : register-specifier width
//   BUBBLE     : value loaded into ID/EXE when a bubble is inserted
package pipe_pkg;

  localparam int unsigned REG_W = 5;

  localparam logic [31:0] BUBBLE = 32'h0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hc_state_t;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones.
//   i_clk   : clock
//   i_clr   : synchronous clear (wins over i_inc)
//   i_inc   : increment this cycle
//   o_count : current count
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the five-stage CPU.
// Drives PC / IF/ID enables, IF/ID and ID/EXE flushes and the EXE/MEM/WB
// freeze for load-use bubbles, taken-branch flushes and data-memory waits
// (with a timeout into a sticky error state).
//   clk, rst (sync, active-high)
//   id_rs, id_rt, id_uses_rt        : source operands of the ID instruction
//   exe_rt, exe_MemRead             : load destination in EXE
//   exe_branch_taken                : branch/jump resolved taken in EXE
//   mem_req, mem_ack                : MEM-stage data-memory handshake
//   pc_en, if_id_en, if_id_flush, id_exe_flush, pipe_freeze : pipeline controls
//   mem_timeout                     : sticky timeout error flag
//   stall_count                     : saturating count of cycles with pc_en=0
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] exe_rt,
  input  logic             exe_MemRead,
  input  logic             exe_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_exe_flush,
  output logic             pipe_freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned WC_W = $clog2(MEM_TIMEOUT + 1);

  hc_state_t       r_state, w_state_nxt;
  logic [WC_W-1:0] r_wait_cnt, w_wait_cnt_nxt;

  logic w_mem_stall;
  logic w_load_use;

  assign w_mem_stall = mem_req & ~mem_ack;
  assign w_load_use  = exe_MemRead & (exe_rt != '0) &
                       ((exe_rt == id_rs) | (id_uses_rt & (exe_rt == id_rt)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  always_comb begin
    pc_en          = 1'b1;
    if_id_en       = 1'b1;
    if_id_flush    = 1'b0;
    id_exe_flush   = 1'b0;
    pipe_freeze    = 1'b0;
    mem_timeout    = 1'b0;
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;

    if (rst) begin
      pc_en          = 1'b0;
      if_id_en       = 1'b0;
      if_id_flush    = 1'b1;
      id_exe_flush   = 1'b1;
      w_state_nxt    = RUN;
      w_wait_cnt_nxt = '0;
    end else begin
      unique case (r_state)
        RUN: begin
          if (w_mem_stall) begin
            pc_en          = 1'b0;
            if_id_en       = 1'b0;
            pipe_freeze    = 1'b1;
            w_state_nxt    = MEM_WAIT;
            w_wait_cnt_nxt = WC_W'(1);
          end else if (exe_branch_taken) begin
            if_id_flush  = 1'b1;
            id_exe_flush = 1'b1;
          end else if (w_load_use) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_exe_flush = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!mem_ack) begin
            // Branch / load-use are deliberately ignored while frozen.
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            pipe_freeze = 1'b1;
            if (r_wait_cnt == WC_W'(MEM_TIMEOUT)) begin
              w_state_nxt = ERROR;
            end else begin
              w_wait_cnt_nxt = r_wait_cnt + WC_W'(1);
            end
          end else begin
            // Released this cycle: apply RUN priorities minus the memory case.
            w_state_nxt    = RUN;
            w_wait_cnt_nxt = '0;
            if (exe_branch_taken) begin
              if_id_flush  = 1'b1;
              id_exe_flush = 1'b1;
            end else if (w_load_use) begin
              pc_en        = 1'b0;
              if_id_en     = 1'b0;
              id_exe_flush = 1'b1;
            end
          end
        end
        ERROR: begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          pipe_freeze = 1'b1;
          mem_timeout = 1'b1;
        end
        default: begin
          w_state_nxt = RUN;
        end
      endcase
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .i_clk   (clk),
    .i_clr   (rst),
    .i_inc   (~pc_en & ~rst),
    .o_count (stall_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl
// (MEM_TIMEOUT=4, CNT_W=4). Inputs change 1 time unit after a rising edge;
// outputs are sampled 1 time unit later, well before the next edge.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, exe_rt;
  logic       id_uses_rt, exe_MemRead, exe_branch_taken, mem_req, mem_ack;
  logic       pc_en, if_id_en, if_id_flush, id_exe_flush, pipe_freeze, mem_timeout;
  logic [3:0] stall_count;
  logic [5:0] outs;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // {pc_en, if_id_en, if_id_flush, id_exe_flush, pipe_freeze, mem_timeout}
  localparam logic [5:0] O_RESET  = 6'b001100;
  localparam logic [5:0] O_IDLE   = 6'b110000;
  localparam logic [5:0] O_LDUSE  = 6'b000100;
  localparam logic [5:0] O_BRANCH = 6'b111100;
  localparam logic [5:0] O_FREEZE = 6'b000010;
  localparam logic [5:0] O_ERROR  = 6'b000011;

  always #5 clk = ~clk;

  assign outs = {pc_en, if_id_en, if_id_flush, id_exe_flush, pipe_freeze, mem_timeout};

  hazard_ctrl #(
    .MEM_TIMEOUT (4),
    .CNT_W       (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .id_rs            (id_rs),
    .id_rt            (id_rt),
    .id_uses_rt       (id_uses_rt),
    .exe_rt           (exe_rt),
    .exe_MemRead      (exe_MemRead),
    .exe_branch_taken (exe_branch_taken),
    .mem_req          (mem_req),
    .mem_ack          (mem_ack),
    .pc_en            (pc_en),
    .if_id_en         (if_id_en),
    .if_id_flush      (if_id_flush),
    .id_exe_flush     (id_exe_flush),
    .pipe_freeze      (pipe_freeze),
    .mem_timeout      (mem_timeout),
    .stall_count      (stall_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; exe_rt = '0;
    id_uses_rt = 1'b0; exe_MemRead = 1'b0; exe_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic chk_o(input string tag, input logic [5:0] exp);
    #1;
    n_vec++;
    assert (outs === exp) else begin
      n_err++;
      $error("FAIL %s: outs observed=%b expected=%b", tag, outs, exp);
    end
  endtask

  task automatic chk_c(input string tag, input logic [3:0] exp);
    n_vec++;
    assert (stall_count === exp) else begin
      n_err++;
      $error("FAIL %s: stall_count observed=%0d expected=%0d", tag, stall_count, exp);
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    chk_o("reset_outs", O_RESET);
    chk_c("reset_cnt", 4'd0);
    rst = 1'b0;
    chk_o("idle", O_IDLE);
    tick();
    chk_c("idle_cnt", 4'd0);

    // load-use on rs
    exe_MemRead = 1'b1; exe_rt = 5'd8; id_rs = 5'd8;
    chk_o("lduse_rs", O_LDUSE);
    tick();
    idle();
    chk_o("lduse_release", O_IDLE);
    chk_c("lduse_cnt", 4'd1);

    // rt match only counts when ID actually reads rt
    exe_MemRead = 1'b1; exe_rt = 5'd5; id_rt = 5'd5; id_rs = 5'd0; id_uses_rt = 1'b0;
    chk_o("rt_unused", O_IDLE);
    id_uses_rt = 1'b1;
    chk_o("lduse_rt", O_LDUSE);
    tick();
    idle();
    chk_c("lduse_rt_cnt", 4'd2);

    // load into $0 never stalls
    exe_MemRead = 1'b1; exe_rt = 5'd0; id_rs = 5'd0;
    chk_o("load_r0", O_IDLE);
    tick();

    // branch beats load-use, no stall counted
    exe_branch_taken = 1'b1; exe_MemRead = 1'b1; exe_rt = 5'd8; id_rs = 5'd8;
    chk_o("branch_lduse", O_BRANCH);
    tick();
    idle();
    chk_c("branch_cnt", 4'd2);

    // memory wait, ack on 3rd MEM_WAIT cycle
    mem_req = 1'b1;
    exe_branch_taken = 1'b1;
    chk_o("mw_cyc0_beats_branch", O_FREEZE);
    tick();
    exe_MemRead = 1'b1; exe_rt = 5'd8; id_rs = 5'd8;
    chk_o("mw_cyc1_ignore", O_FREEZE);
    tick();
    idle(); mem_req = 1'b1;
    chk_o("mw_cyc2", O_FREEZE);
    tick();
    mem_ack = 1'b1; exe_branch_taken = 1'b1;
    chk_o("mw_ack_branch", O_BRANCH);
    tick();
    idle();
    chk_o("mw_back_run", O_IDLE);
    chk_c("mw_cnt", 4'd5);

    // request with same-cycle ack is not a wait
    mem_req = 1'b1; mem_ack = 1'b1;
    chk_o("req_ack_same", O_IDLE);
    tick();
    idle();

    // timeout with MEM_TIMEOUT=4
    mem_req = 1'b1;
    chk_o("to_cyc0", O_FREEZE);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk_o($sformatf("to_cyc%0d", i), O_FREEZE);
    end
    tick();
    chk_o("to_cyc5_error", O_ERROR);
    chk_c("to_cnt", 4'd10);
    mem_ack = 1'b1;
    tick();
    chk_o("error_sticky", O_ERROR);

    // saturation: 19 stall cycles total
    for (int i = 0; i < 4; i++) tick();
    chk_c("sat_reach", 4'd15);
    for (int i = 0; i < 4; i++) tick();
    chk_c("sat_hold", 4'd15);
    chk_o("error_hold", O_ERROR);

    // reset out of ERROR
    idle();
    rst = 1'b1;
    chk_o("rst_in_error", O_RESET);
    tick();
    chk_c("rst_cnt_clr", 4'd0);
    chk_o("rst_outs", O_RESET);
    rst = 1'b0;
    chk_o("after_rst_run", O_IDLE);
    tick();
    chk_c("after_rst_cnt", 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
